hash_cmd_generator: RTL and testbench
=====================================

HASH_CMD_GENERATOR -- requirements
Module: hash_cmd_generator

Interface
REQ-001 SHALL have parameter HASH_WIDTH, default 32, meaning hash bits delivered per command (1..32).
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, meaning byte-offset width.
REQ-003 SHALL have parameter HASH_PRIME, default 32'h9E3779B1, meaning the multiplicative hash constant.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-006 SHALL have port in_valid, input, 1 bit: an input byte is offered.
REQ-007 SHALL have port in_data, input, 8 bits: the input byte.
REQ-008 SHALL have port in_last, input, 1 bit: the offered byte is the last byte of its frame.
REQ-009 SHALL have port in_ready, output, 1 bit: the block can accept a byte this cycle.
REQ-010 SHALL have port cmd_push, output, 1 bit: write strobe to the match-engine command queue.
REQ-011 SHALL have port cmd_hash, output, HASH_WIDTH bits: hash of the 4-byte window.
REQ-012 SHALL have port cmd_offset, output, ADDR_WIDTH bits: frame offset of the window's first byte.
REQ-013 SHALL have port cmd_full, input, 1 bit: the command queue is full.
REQ-014 SHALL have port busy, output, 1 bit: a command is pending or a frame is partially received.

Function
REQ-015 SHALL accept a byte only in a cycle where in_valid && in_ready; no other cycle changes window, counters or state.
REQ-016 SHALL hold at most one pending command in an output register (pend); in_ready = !pend || !cmd_full.
REQ-017 SHALL drive cmd_push = pend && !cmd_full, decoded only from registered state; a push and a new load of pend in the same cycle are legal.
REQ-018 SHALL hold cmd_hash and cmd_offset stable while pend && cmd_full.
REQ-019 SHALL keep a 32-bit window of the last four accepted bytes, little-endian: window = {b[i+3], b[i+2], b[i+1], b[i]}, where b[i] is the oldest byte.
REQ-020 SHALL compute cmd_hash = bits [31:32-HASH_WIDTH] of (window * HASH_PRIME) mod 2^32.
REQ-021 SHALL have two states. FILL: fill_cnt runs 0..3 and no command is produced. RUN: every accepted byte produces one command.
REQ-022 SHALL go from FILL to RUN on the 4th accepted byte of a frame, and that byte SHALL load the first command, with offset 0.
REQ-023 SHALL, for a byte accepted in cycle N that completes a window, assert cmd_push in cycle N+1 if cmd_full is low.
REQ-024 SHALL give cmd_offset = (count of frame bytes accepted before the window's first byte) mod 2^ADDR_WIDTH; the offset wraps silently.
REQ-025 SHALL, when a byte with in_last is accepted, still emit the command that byte completes, then enter FILL with fill_cnt = 0 and the offset counter = 0.
REQ-026 SHALL emit no command for a frame shorter than 4 bytes, and no bytes carry over to the next frame.
REQ-027 SHALL drive busy = pend || (state == RUN) || (fill_cnt != 0).

Reset
REQ-028 SHALL, with rst_n low at a clock edge, set state = FILL, fill_cnt = 0, offset = 0, window = 0, pend = 0; outputs SHALL be cmd_push = 0, cmd_hash = 0, cmd_offset = 0, busy = 0, and in_ready = 1 after the reset edge.
REQ-029 SHALL discard a pending command and any partial frame if reset is asserted mid-frame; no push occurs in the cycle after the reset edge.

Configuration
REQ-030 SHALL, when macro HASH_CMD_COUNT_EN is defined, add output cmd_count (32 bits): the number of cmd_push cycles since reset, wrapping at 2^32, reset to 0.
REQ-031 SHALL, when HASH_CMD_COUNT_EN is undefined, not have the cmd_count port or counter; all other behaviour is identical.

Structure
REQ-032 SHALL take the default HASH_PRIME, the FILL/RUN state enum and the window width constant (32) from shared package zstd_accel_pkg.
REQ-033 SHALL put the window-times-prime multiply and bit select in sub-module window_hasher (purely combinational); the control logic stays in hash_cmd_generator.

Verification
REQ-034 SHALL cover: bytes 01,00,00,00 with last on the 4th byte and cmd_full = 0 -> one push, hash 32'h9E3779B1, offset 0, then busy = 0.
REQ-035 SHALL cover: bytes 01,00,00,00,00 streamed -> two pushes, hashes 9E3779B1 then 00000000, offsets 0 then 1.
REQ-036 SHALL cover: cmd_full held high for 5 cycles while in RUN -> at most one pending command, in_ready = 0, outputs stable; the push occurs in the first cycle cmd_full = 0.
REQ-037 SHALL cover: a 3-byte frame with last, then bytes 02,00,00,00 -> exactly one push, hash 3C6EF362, offset 0.
REQ-038 SHALL cover: with ADDR_WIDTH = 4, a 20-byte frame -> offsets run 0..15 then 0 (wrap), for 17 pushes in total.
REQ-039 SHALL cover: rst_n pulsed low for one cycle while pend = 1 mid-frame -> no push follows, and a new frame starts at offset 0; with HASH_CMD_COUNT_EN defined, cmd_count = 0 after reset.

Source files
------------

// File: rtl/zstd_accel_pkg.sv
// Shared constants and types for the zstd accelerator front end.
package zstd_accel_pkg;

    localparam int WIN_W = 32;
    localparam logic [WIN_W-1:0] DEFAULT_HASH_PRIME = 32'h9E3779B1;

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_RUN  = 1'b1
    } hcg_state_e;

    // Newest byte enters at the top; the oldest byte ends up in bits [7:0].
    function automatic logic [WIN_W-1:0] shift_window(
        input logic [WIN_W-1:0] win,
        input logic [7:0]       data
    );
        return {data, win[WIN_W-1:8]};
    endfunction

endpackage

// File: rtl/hash_cmd_generator_window_hasher.sv
// Multiplicative hash of a 4-byte window; returns the top HASH_WIDTH bits.
module window_hasher
    import zstd_accel_pkg::*;
#(
    parameter int               HASH_WIDTH = 32,
    parameter logic [WIN_W-1:0] HASH_PRIME = DEFAULT_HASH_PRIME
) (
    input  logic [WIN_W-1:0]      window,
    output logic [HASH_WIDTH-1:0] hash
);

    logic [WIN_W-1:0] product;

    assign product = window * HASH_PRIME;
    assign hash    = product[WIN_W-1 -: HASH_WIDTH];

endmodule

// File: rtl/hash_cmd_generator.sv
// Byte stream to hash-command generator for the match engine.
// Define HASH_CMD_COUNT_EN to add the cmd_count push counter output.
module hash_cmd_generator
    import zstd_accel_pkg::*;
#(
    parameter int               HASH_WIDTH = 32,
    parameter int               ADDR_WIDTH = 32,
    parameter logic [WIN_W-1:0] HASH_PRIME = DEFAULT_HASH_PRIME
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    input  logic                  in_last,
    output logic                  in_ready,
    output logic                  cmd_push,
    output logic [HASH_WIDTH-1:0] cmd_hash,
    output logic [ADDR_WIDTH-1:0] cmd_offset,
    input  logic                  cmd_full,
    output logic                  busy
`ifdef HASH_CMD_COUNT_EN
    ,
    output logic [31:0]           cmd_count
`endif
);

    hcg_state_e            state;
    logic [1:0]            fill_cnt;
    logic [ADDR_WIDTH-1:0] offset;
    logic [WIN_W-1:0]      window;
    logic                  pend;

    logic                  accept;
    logic                  completes;
    logic [WIN_W-1:0]      next_window;
    logic [HASH_WIDTH-1:0] next_hash;

    assign in_ready    = !pend || !cmd_full;
    assign cmd_push    = pend && !cmd_full;
    assign accept      = in_valid && in_ready;
    assign completes   = (state == ST_RUN) || (fill_cnt == 2'd3);
    assign next_window = shift_window(window, in_data);
    assign busy        = pend || (state == ST_RUN) || (fill_cnt != 2'd0);

    window_hasher #(
        .HASH_WIDTH (HASH_WIDTH),
        .HASH_PRIME (HASH_PRIME)
    ) u_hasher (
        .window (next_window),
        .hash   (next_hash)
    );

    // offset always holds the start of the next window; it is 0 during FILL.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_FILL;
            fill_cnt   <= 2'd0;
            offset     <= '0;
            window     <= '0;
            pend       <= 1'b0;
            cmd_hash   <= '0;
            cmd_offset <= '0;
        end else begin
            if (cmd_push) begin
                pend <= 1'b0;
            end
            if (accept) begin
                window <= next_window;
                if (completes) begin
                    pend       <= 1'b1;
                    cmd_hash   <= next_hash;
                    cmd_offset <= offset;
                end
                if (in_last) begin
                    state    <= ST_FILL;
                    fill_cnt <= 2'd0;
                    offset   <= '0;
                end else if (state == ST_FILL) begin
                    if (fill_cnt == 2'd3) begin
                        state    <= ST_RUN;
                        fill_cnt <= 2'd0;
                        offset   <= ADDR_WIDTH'(1);
                    end else begin
                        fill_cnt <= fill_cnt + 2'd1;
                    end
                end else begin
                    offset <= offset + ADDR_WIDTH'(1);
                end
            end
        end
    end

`ifdef HASH_CMD_COUNT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cmd_count <= 32'd0;
        end else if (cmd_push) begin
            cmd_count <= cmd_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hash_cmd_generator.sv
// Self-checking bench for hash_cmd_generator with a frame-level reference model.
module tb_hash_cmd_generator;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_last;
    logic        cmd_full;

    logic        in_ready, cmd_push, busy;
    logic [31:0] cmd_hash, cmd_offset;
    logic        in_ready4, cmd_push4, busy4;
    logic [31:0] cmd_hash4;
    logic [3:0]  cmd_offset4;
`ifdef HASH_CMD_COUNT_EN
    logic [31:0] cmd_count, cmd_count4;
`endif

    int checks = 0;
    int failures = 0;

    logic [7:0]  frame[$];
    logic [31:0] exp_hash[$];
    logic [31:0] exp_off[$];
    logic [31:0] got_hash[$];
    logic [31:0] got_off[$];
    logic [3:0]  got_off4[$];

    always #5 clk = ~clk;

    hash_cmd_generator dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_last(in_last), .in_ready(in_ready), .cmd_push(cmd_push),
        .cmd_hash(cmd_hash), .cmd_offset(cmd_offset), .cmd_full(cmd_full),
        .busy(busy)
`ifdef HASH_CMD_COUNT_EN
        , .cmd_count(cmd_count)
`endif
    );

    hash_cmd_generator #(.ADDR_WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_last(in_last), .in_ready(in_ready4), .cmd_push(cmd_push4),
        .cmd_hash(cmd_hash4), .cmd_offset(cmd_offset4), .cmd_full(cmd_full),
        .busy(busy4)
`ifdef HASH_CMD_COUNT_EN
        , .cmd_count(cmd_count4)
`endif
    );

    always @(negedge clk) begin
        if (rst_n && cmd_push) begin
            got_hash.push_back(cmd_hash);
            got_off.push_back(cmd_offset);
        end
        if (rst_n && cmd_push4) begin
            got_off4.push_back(cmd_offset4);
        end
    end

    function automatic logic [31:0] ref_hash(input logic [31:0] w);
        logic [63:0] p;
        p = 64'(w) * 64'h9E3779B1;
        return p[31:0];
    endfunction

    // Model: every frame byte from the 4th on closes a window starting 3 bytes back.
    task automatic model_byte(input logic [7:0] d, input logic l);
        int n;
        frame.push_back(d);
        n = frame.size();
        if (n >= 4) begin
            exp_hash.push_back(ref_hash({frame[n-1], frame[n-2], frame[n-3], frame[n-4]}));
            exp_off.push_back(32'(n - 4));
        end
        if (l) frame.delete();
    endtask

    task automatic clear_queues();
        frame.delete();
        exp_hash.delete();
        exp_off.delete();
        got_hash.delete();
        got_off.delete();
        got_off4.delete();
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_data = 8'h00;
        in_last = 1'b0;
        cmd_full = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        clear_queues();
    endtask

    task automatic send_byte(input logic [7:0] d, input logic l, input bit rnd_full);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data = d;
        in_last = l;
        if (rnd_full) cmd_full = ($urandom % 3 == 0);
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(posedge clk);
            #1;
            if (rnd_full) cmd_full = ($urandom % 2 == 0);
            n++;
            @(negedge clk);
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout in_ready=%b required=1", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last = 1'b0;
        model_byte(d, l);
    endtask

    task automatic drain();
        cmd_full = 1'b0;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        apply_reset();
        @(negedge clk);
        checks++;
        if ({cmd_push, busy, in_ready} !== 3'b001) begin
            failures++;
            $display("FAIL reset_ctrl push/busy/ready=%b required=001", {cmd_push, busy, in_ready});
        end
        checks++;
        if (cmd_hash !== 32'h0 || cmd_offset !== 32'h0) begin
            failures++;
            $display("FAIL reset_cmd hash=%h off=%h required 0/0", cmd_hash, cmd_offset);
        end
`ifdef HASH_CMD_COUNT_EN
        checks++;
        if (cmd_count !== 32'd0) begin
            failures++;
            $display("FAIL reset_count got=%0d required=0", cmd_count);
        end
`endif
    endtask

    task automatic test_single_frame();
        apply_reset();
        send_byte(8'h01, 1'b0, 1'b0);
        send_byte(8'h00, 1'b0, 1'b0);
        send_byte(8'h00, 1'b0, 1'b0);
        send_byte(8'h00, 1'b1, 1'b0);
        @(negedge clk);
        checks++;
        if (cmd_push !== 1'b1) begin
            failures++;
            $display("FAIL single_latency push=%b required=1", cmd_push);
        end
        drain();
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL single_busy got=%b required=0", busy);
        end
        checks++;
        if (got_hash.size() != 1) begin
            failures++;
            $display("FAIL single_count got=%0d required=1", got_hash.size());
        end else begin
            checks++;
            if (got_hash[0] !== 32'h9E3779B1 || got_off[0] !== 32'd0) begin
                failures++;
                $display("FAIL single_cmd hash=%h off=%0d required 9e3779b1/0", got_hash[0], got_off[0]);
            end
        end
    endtask

    task automatic test_stream();
        apply_reset();
        send_byte(8'h01, 1'b0, 1'b0);
        send_byte(8'h00, 1'b0, 1'b0);
        send_byte(8'h00, 1'b0, 1'b0);
        send_byte(8'h00, 1'b0, 1'b0);
        send_byte(8'h00, 1'b1, 1'b0);
        drain();
        checks++;
        if (got_hash.size() != 2) begin
            failures++;
            $display("FAIL stream_count got=%0d required=2", got_hash.size());
        end else begin
            checks++;
            if (got_hash[0] !== 32'h9E3779B1 || got_hash[1] !== 32'h0) begin
                failures++;
                $display("FAIL stream_hash got=%h,%h required 9e3779b1,00000000", got_hash[0], got_hash[1]);
            end
            checks++;
            if (got_off[0] !== 32'd0 || got_off[1] !== 32'd1) begin
                failures++;
                $display("FAIL stream_off got=%0d,%0d required 0,1", got_off[0], got_off[1]);
            end
        end
    endtask

    task automatic test_backpressure();
        int stall_bad;
        stall_bad = 0;
        apply_reset();
        send_byte(8'h01, 1'b0, 1'b0);
        send_byte(8'h00, 1'b0, 1'b0);
        send_byte(8'h00, 1'b0, 1'b0);
        cmd_full = 1'b1;
        send_byte(8'h00, 1'b0, 1'b0);
        in_valid = 1'b1;
        in_data = 8'hAA;
        in_last = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (in_ready !== 1'b0 || cmd_push !== 1'b0 ||
                cmd_hash !== 32'h9E3779B1 || cmd_offset !== 32'd0) stall_bad++;
            @(posedge clk);
        end
        checks++;
        if (stall_bad != 0) begin
            failures++;
            $display("FAIL stall_hold bad_cycles=%0d required=0", stall_bad);
        end
        #1 cmd_full = 1'b0;
        @(negedge clk);
        checks++;
        if (cmd_push !== 1'b1 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL stall_release push/ready=%b%b required=11", cmd_push, in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last = 1'b0;
        drain();
        checks++;
        if (got_hash.size() != 2) begin
            failures++;
            $display("FAIL stall_count got=%0d required=2", got_hash.size());
        end else begin
            checks++;
            if (got_hash[1] !== 32'h8A000000 || got_off[1] !== 32'd1) begin
                failures++;
                $display("FAIL stall_second hash=%h off=%0d required 8a000000/1", got_hash[1], got_off[1]);
            end
        end
    endtask

    task automatic test_short_frame();
        apply_reset();
        send_byte(8'hAA, 1'b0, 1'b0);
        send_byte(8'hBB, 1'b0, 1'b0);
        send_byte(8'hCC, 1'b1, 1'b0);
        send_byte(8'h02, 1'b0, 1'b0);
        send_byte(8'h00, 1'b0, 1'b0);
        send_byte(8'h00, 1'b0, 1'b0);
        send_byte(8'h00, 1'b1, 1'b0);
        drain();
        checks++;
        if (got_hash.size() != 1) begin
            failures++;
            $display("FAIL short_count got=%0d required=1", got_hash.size());
        end else begin
            checks++;
            if (got_hash[0] !== 32'h3C6EF362 || got_off[0] !== 32'd0) begin
                failures++;
                $display("FAIL short_cmd hash=%h off=%0d required 3c6ef362/0", got_hash[0], got_off[0]);
            end
        end
    endtask

    task automatic test_wrap();
        int bad;
        bad = 0;
        apply_reset();
        for (int i = 0; i < 20; i++) begin
            send_byte(8'($urandom), (i == 19), 1'b0);
        end
        drain();
        checks++;
        if (got_off4.size() != 17 || got_hash.size() != 17) begin
            failures++;
            $display("FAIL wrap_count got=%0d/%0d required=17", got_off4.size(), got_hash.size());
        end else begin
            for (int k = 0; k < 17; k++) begin
                if (got_off4[k] !== 4'(k % 16)) bad++;
                if (got_off[k] !== exp_off[k] || got_hash[k] !== exp_hash[k]) bad++;
            end
            checks++;
            if (bad != 0) begin
                failures++;
                $display("FAIL wrap_offsets bad=%0d required=0 last_off4=%0d", bad, got_off4[16]);
            end
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        send_byte(8'h01, 1'b0, 1'b0);
        send_byte(8'h02, 1'b0, 1'b0);
        send_byte(8'h03, 1'b0, 1'b0);
        cmd_full = 1'b1;
        send_byte(8'h04, 1'b0, 1'b0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cmd_full = 1'b0;
        clear_queues();
        @(negedge clk);
        checks++;
        if (cmd_push !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL midreset_flush push/busy=%b%b required=00", cmd_push, busy);
        end
`ifdef HASH_CMD_COUNT_EN
        checks++;
        if (cmd_count !== 32'd0) begin
            failures++;
            $display("FAIL midreset_count got=%0d required=0", cmd_count);
        end
`endif
        @(posedge clk);
        #1;
        send_byte(8'h05, 1'b0, 1'b0);
        send_byte(8'h06, 1'b0, 1'b0);
        send_byte(8'h07, 1'b0, 1'b0);
        send_byte(8'h08, 1'b1, 1'b0);
        drain();
        checks++;
        if (got_hash.size() != 1) begin
            failures++;
            $display("FAIL midreset_pushes got=%0d required=1", got_hash.size());
        end else begin
            checks++;
            if (got_hash[0] !== ref_hash(32'h08070605) || got_off[0] !== 32'd0) begin
                failures++;
                $display("FAIL midreset_cmd hash=%h off=%0d required %h/0", got_hash[0], got_off[0], ref_hash(32'h08070605));
            end
        end
    endtask

    task automatic test_random();
        int bad;
        int len;
        bad = 0;
        apply_reset();
        for (int f = 0; f < 12; f++) begin
            len = $urandom_range(1, 10);
            for (int i = 0; i < len; i++) begin
                send_byte(8'($urandom), (i == len - 1), 1'b1);
            end
        end
        drain();
        checks++;
        if (got_hash.size() != exp_hash.size()) begin
            failures++;
            $display("FAIL random_count got=%0d required=%0d", got_hash.size(), exp_hash.size());
        end else begin
            for (int k = 0; k < exp_hash.size(); k++) begin
                if (got_hash[k] !== exp_hash[k] || got_off[k] !== exp_off[k]) bad++;
            end
            checks++;
            if (bad != 0) begin
                failures++;
                $display("FAIL random_cmds bad=%0d required=0", bad);
            end
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL random_idle busy=%b required=0", busy);
        end
`ifdef HASH_CMD_COUNT_EN
        checks++;
        if (cmd_count !== 32'(exp_hash.size())) begin
            failures++;
            $display("FAIL random_cmd_count got=%0d required=%0d", cmd_count, exp_hash.size());
        end
`endif
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_stream();
        test_backpressure();
        test_short_frame();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
